// File: rtl/cola_comandos.sv
// rtl/cola_comandos.sv - button synchroniser/debouncer, command encoder and command queue
module cola_comandos #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int DEPTH           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arriba,
    input  logic       abajo,
    input  logic       izquierda,
    input  logic       derecha,
    input  logic       pausa,
    input  logic       LE,
    output logic [2:0] comando,
    output logic       vacia,
    output logic       llena,
    output logic       descartado
);
    localparam int PW = $clog2(DEPTH);

    // bit order: 0 arriba, 1 abajo, 2 izquierda, 3 derecha, 4 pausa
    logic [4:0]       raw, sync1, sync2, deb, deb_q, ev;
    logic [CNT_W-1:0] cnt [5];
    logic [PW:0]      wr, rd, wr_last;
    logic [2:0]       mem [DEPTH];
    logic [2:0]       code;
    logic             multi, dup, want, pop, push, drop;

    assign raw = {pausa, derecha, izquierda, abajo, arriba};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ev      = deb & ~deb_q;
    assign multi   = (ev & (ev - 5'd1)) != 5'd0;
    assign wr_last = wr - (PW + 1)'(1);

    always_comb begin
        code = 3'd0;
        if (ev[4])      code = 3'd5;
        else if (ev[0]) code = 3'd1;
        else if (ev[1]) code = 3'd2;
        else if (ev[2]) code = 3'd3;
        else if (ev[3]) code = 3'd4;
    end

    // pause is never filtered so pause/resume pairs always reach the state machine
    assign dup  = !vacia && (code != 3'd5) && (code == mem[wr_last[PW-1:0]]);
    assign want = (code != 3'd0) && !dup;
    assign pop  = !LE && !vacia;
    assign push = want && (!llena || pop);
    assign drop = multi || (want && llena && !pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr         <= '0;
            rd         <= '0;
            descartado <= 1'b0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop)  rd <= rd + 1'b1;
            descartado <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr[PW-1:0]] <= code;
    end

    assign vacia   = (wr == rd);
    assign llena   = (wr[PW] != rd[PW]) && (wr[PW-1:0] == rd[PW-1:0]);
    assign comando = vacia ? 3'd0 : mem[rd[PW-1:0]];
endmodule

// File: tb/tb_cola_comandos.sv
// tb/tb_cola_comandos.sv - directed table-driven bench for cola_comandos
module tb_cola_comandos;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic       LE  = 1'b1;
    logic [2:0] comando;
    logic       vacia, llena, descartado;
    int         total = 0;
    int         bad   = 0;
    int         drops = 0;

    localparam logic [4:0] ARR = 5'b00001, ABA = 5'b00010, IZQ = 5'b00100,
                           DER = 5'b01000, PAU = 5'b10000;

    cola_comandos #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .arriba(btn[0]), .abajo(btn[1]), .izquierda(btn[2]), .derecha(btn[3]), .pausa(btn[4]),
        .LE(LE), .comando(comando), .vacia(vacia), .llena(llena), .descartado(descartado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (descartado) drops++;

    typedef struct {
        logic [4:0] b;
        bit         le_push;
        bit         pop;
        logic [2:0] cmd;
        logic       vac;
        logic       full;
        int         ndrop;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // push lands on the 7th edge after the drive; le_push holds LE low for exactly that edge
    task automatic press(input logic [4:0] m, input bit le_push);
        @(posedge clk); #1 btn = m;
        repeat (6) @(posedge clk);
        if (le_push) begin
            #1 LE = 1'b0;
            @(posedge clk); #1 LE = 1'b1;
        end else begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1 btn = '0;
        repeat (10) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 LE = 1'b0;
        @(posedge clk); #1 LE = 1'b1;
    endtask

    vec_t vt [26];

    initial begin
        int lat;
        int d0;
        vt[0]  = '{DER, 0, 0, 3'd4, 1'b0, 1'b0, 0};
        vt[1]  = '{ABA, 0, 0, 3'd4, 1'b0, 1'b0, 0};
        vt[2]  = '{IZQ, 0, 0, 3'd4, 1'b0, 1'b0, 0};
        vt[3]  = '{5'd0, 0, 1, 3'd2, 1'b0, 1'b0, 0};
        vt[4]  = '{5'd0, 0, 1, 3'd3, 1'b0, 1'b0, 0};
        vt[5]  = '{5'd0, 0, 1, 3'd0, 1'b1, 1'b0, 0};
        vt[6]  = '{DER, 0, 0, 3'd4, 1'b0, 1'b0, 0};
        vt[7]  = '{DER, 0, 0, 3'd4, 1'b0, 1'b0, 0};
        vt[8]  = '{5'd0, 0, 1, 3'd0, 1'b1, 1'b0, 0};
        vt[9]  = '{PAU, 0, 0, 3'd5, 1'b0, 1'b0, 0};
        vt[10] = '{PAU, 0, 0, 3'd5, 1'b0, 1'b0, 0};
        vt[11] = '{5'd0, 0, 1, 3'd5, 1'b0, 1'b0, 0};
        vt[12] = '{5'd0, 0, 1, 3'd0, 1'b1, 1'b0, 0};
        vt[13] = '{ARR, 0, 0, 3'd1, 1'b0, 1'b0, 0};
        vt[14] = '{ABA, 0, 0, 3'd1, 1'b0, 1'b0, 0};
        vt[15] = '{ARR, 0, 0, 3'd1, 1'b0, 1'b0, 0};
        vt[16] = '{ABA, 0, 0, 3'd1, 1'b0, 1'b1, 0};
        vt[17] = '{ARR, 0, 0, 3'd1, 1'b0, 1'b1, 1};
        vt[18] = '{DER, 1, 0, 3'd2, 1'b0, 1'b1, 0};
        vt[19] = '{5'd0, 0, 1, 3'd1, 1'b0, 1'b0, 0};
        vt[20] = '{5'd0, 0, 1, 3'd2, 1'b0, 1'b0, 0};
        vt[21] = '{5'd0, 0, 1, 3'd4, 1'b0, 1'b0, 0};
        vt[22] = '{5'd0, 0, 1, 3'd0, 1'b1, 1'b0, 0};
        vt[23] = '{ARR | PAU, 0, 0, 3'd5, 1'b0, 1'b0, 1};
        vt[24] = '{5'd0, 0, 1, 3'd0, 1'b1, 1'b0, 0};
        vt[25] = '{5'd0, 0, 1, 3'd0, 1'b1, 1'b0, 0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_comando", comando, 0);
        chk("rst_vacia", vacia, 1);
        chk("rst_llena", llena, 0);
        chk("rst_descartado", descartado, 0);
        rst = 1'b0;

        // short glitch is ignored
        @(posedge clk); #1 btn = ARR;
        repeat (3) @(posedge clk);
        #1 btn = '0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("glitch_vacia", vacia, 1);

        // latency and single entry for a long hold
        @(posedge clk); #1 btn = ARR;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && comando != 3'd0) lat = k;
        end
        chk("latency_in_range", int'(lat >= 6 && lat <= 8), 1);
        btn = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("hold_comando", comando, 1);
        pop_one();
        @(negedge clk);
        chk("hold_single_entry", vacia, 1);

        // async reset mid-cycle with two entries queued
        press(ARR, 0);
        press(ABA, 0);
        @(negedge clk);
        chk("pre_rst_comando", comando, 1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_rst_comando", comando, 0);
        chk("async_rst_vacia", vacia, 1);
        chk("async_rst_llena", llena, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 26; i++) begin
            d0 = drops;
            if (vt[i].b != 5'd0) press(vt[i].b, vt[i].le_push);
            if (vt[i].pop) pop_one();
            @(negedge clk);
            chk($sformatf("v%0d_comando", i), comando, vt[i].cmd);
            chk($sformatf("v%0d_vacia", i), vacia, vt[i].vac);
            chk($sformatf("v%0d_llena", i), llena, vt[i].full);
            chk($sformatf("v%0d_descartado", i), drops - d0, vt[i].ndrop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
